// File: rtl/switch_logic_eval_if.sv
// Board-pin bundle for switch_logic_eval: raw switches/button in, LEDs and mode out.
// TOGGLE_COUNT_O is present only when SWITCH_EVAL_TOGGLE_CNT_EN is defined.
interface switch_logic_eval_if #(
  parameter int NUM_GROUPS = 4,
  parameter int GROUP_W    = 4
);
  logic [NUM_GROUPS*GROUP_W-1:0] SWITCH_I;
  logic                          PUSH_BUTTON_N_I;
  logic [NUM_GROUPS*GROUP_W-1:0] LED_RED_O;
  logic [NUM_GROUPS-1:0]         LED_GREEN_O;
  logic [2:0]                    MODE_O;
`ifdef SWITCH_EVAL_TOGGLE_CNT_EN
  logic [7:0]                    TOGGLE_COUNT_O;

  modport master (output SWITCH_I, PUSH_BUTTON_N_I,
                  input  LED_RED_O, LED_GREEN_O, MODE_O, TOGGLE_COUNT_O);
  modport slave  (input  SWITCH_I, PUSH_BUTTON_N_I,
                  output LED_RED_O, LED_GREEN_O, MODE_O, TOGGLE_COUNT_O);
`else
  modport master (output SWITCH_I, PUSH_BUTTON_N_I,
                  input  LED_RED_O, LED_GREEN_O, MODE_O);
  modport slave  (input  SWITCH_I, PUSH_BUTTON_N_I,
                  output LED_RED_O, LED_GREEN_O, MODE_O);
`endif
endinterface

// File: rtl/switch_logic_eval.sv
// Debounced per-group switch reduction with a push-button mode selector.
// Optional SWITCH_EVAL_TOGGLE_CNT_EN adds a saturating LED_GREEN_O change counter.

// One synchronised, debounced input bit.
module sle_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {2{RST_VAL}};
      cnt  <= '0;
      dout <= RST_VAL;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module switch_logic_eval #(
  parameter int NUM_GROUPS      = 4,
  parameter int GROUP_W         = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               CLOCK_50_I,
  input  logic               RESETN_I,
  switch_logic_eval_if.slave bus
);
  localparam int NW = NUM_GROUPS * GROUP_W;

  typedef enum logic [2:0] {
    M_AND  = 3'd0,
    M_OR   = 3'd1,
    M_XOR  = 3'd2,
    M_NAND = 3'd3,
    M_NOR  = 3'd4,
    M_XNOR = 3'd5
  } mode_e;

  mode_e                              mode;
  logic [NW-1:0]                      sw_stable;
  logic [NUM_GROUPS-1:0][GROUP_W-1:0] grp;
  logic                               btn_stable, btn_prev, press;
  logic [NUM_GROUPS-1:0]              green, green_nxt;

  sle_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_sw [NW-1:0] (
    .clk(CLOCK_50_I), .rst_n(RESETN_I), .din(bus.SWITCH_I), .dout(sw_stable)
  );

  // Button idles high, so its synchroniser and stable level reset to 1.
  sle_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_btn (
    .clk(CLOCK_50_I), .rst_n(RESETN_I), .din(bus.PUSH_BUTTON_N_I), .dout(btn_stable)
  );

  assign grp   = sw_stable;
  assign press = btn_prev & ~btn_stable;

  always_comb begin
    green_nxt = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      case (mode)
        M_AND:   green_nxt[g] =  &grp[g];
        M_OR:    green_nxt[g] =  |grp[g];
        M_XOR:   green_nxt[g] =  ^grp[g];
        M_NAND:  green_nxt[g] = ~&grp[g];
        M_NOR:   green_nxt[g] = ~|grp[g];
        M_XNOR:  green_nxt[g] = ~^grp[g];
        default: green_nxt[g] =  &grp[g];
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (!RESETN_I) begin
      mode     <= M_AND;
      btn_prev <= 1'b1;
      green    <= '1;
    end else begin
      btn_prev <= btn_stable;
      green    <= green_nxt;
      case (mode)
        M_AND:   if (press) mode <= M_OR;
        M_OR:    if (press) mode <= M_XOR;
        M_XOR:   if (press) mode <= M_NAND;
        M_NAND:  if (press) mode <= M_NOR;
        M_NOR:   if (press) mode <= M_XNOR;
        M_XNOR:  if (press) mode <= M_AND;
        default: mode <= M_AND;
      endcase
    end
  end

  assign bus.LED_RED_O   = sw_stable;
  assign bus.LED_GREEN_O = green;
  assign bus.MODE_O      = mode;

`ifdef SWITCH_EVAL_TOGGLE_CNT_EN
  logic [7:0] tcnt;

  // green_nxt != green means the registered LEDs change on this edge.
  always_ff @(posedge CLOCK_50_I) begin
    if (!RESETN_I)                              tcnt <= '0;
    else if (green_nxt != green && tcnt != 8'hFF) tcnt <= tcnt + 8'd1;
  end

  assign bus.TOGGLE_COUNT_O = tcnt;
`endif
endmodule

// File: tb/tb_switch_logic_eval.sv
// Scoreboard bench for switch_logic_eval with DEBOUNCE_CYCLES=4 and 4 groups of 4 switches.
module tb_switch_logic_eval;
  localparam int NG = 4, GW = 4, DB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  switch_logic_eval_if #(.NUM_GROUPS(NG), .GROUP_W(GW)) bus ();

  switch_logic_eval #(.NUM_GROUPS(NG), .GROUP_W(GW), .DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50_I(clk), .RESETN_I(rst_n), .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [15:0] red;
    logic [3:0]  green;
    logic [2:0]  mode;
    int          tcnt;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   errors = 0, checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_expt(int dc, logic [15:0] r, logic [3:0] g, logic [2:0] m, int t, string n);
    exp_t e;
    e.cyc = cyc + dc; e.red = r; e.green = g; e.mode = m; e.tcnt = t; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic push_exp(int dc, logic [15:0] r, logic [3:0] g, logic [2:0] m, string n);
    push_expt(dc, r, g, m, -1, n);
  endtask

  task automatic check(exp_t e);
    int act_t;
    logic tbad;
    act_t = -1;
    tbad  = 1'b0;
`ifdef SWITCH_EVAL_TOGGLE_CNT_EN
    act_t = int'(bus.TOGGLE_COUNT_O);
    if (e.tcnt >= 0 && act_t != e.tcnt) tbad = 1'b1;
`endif
    checks++;
    if (e.cyc != cyc || bus.LED_RED_O !== e.red || bus.LED_GREEN_O !== e.green ||
        bus.MODE_O !== e.mode || tbad) begin
      errors++;
      $display("FAIL %s cyc=%0d(due %0d): got red=%h green=%b mode=%0d tcnt=%0d, need red=%h green=%b mode=%0d tcnt=%0d",
               e.name, cyc, e.cyc, bus.LED_RED_O, bus.LED_GREEN_O, bus.MODE_O, act_t,
               e.red, e.green, e.mode, e.tcnt);
    end
  endtask

  // Monitor: compares every expectation that falls due on this cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        check(sbq[i]);
        sbq.delete(i);
      end
    end
  end

  logic [3:0] gtab [6];
  int m;

  initial begin
    gtab = '{4'b0100, 4'b0111, 4'b0001, 4'b1011, 4'b1000, 4'b1110};
    rst_n = 1'b0;
    bus.SWITCH_I = 16'h0000;
    bus.PUSH_BUTTON_N_I = 1'b1;

    // Reset values, then AND(0)=0 one cycle after release
    step(1);
    push_exp(1, 16'h0, 4'hF, 3'd0, "reset_hold");
    push_exp(2, 16'h0, 4'hF, 3'd0, "reset_last");
    step(2);
    rst_n = 1'b1;
    push_exp(1, 16'h0, 4'h0, 3'd0, "post_reset_and0");
    step(3);

    // Latency of a clean switch edge
    bus.SWITCH_I = 16'h0F00;
    push_exp(5, 16'h0000, 4'h0,    3'd0, "red_before_6");
    push_exp(6, 16'h0F00, 4'h0,    3'd0, "red_at_6");
    push_exp(7, 16'h0F00, 4'b0100, 3'd0, "green_at_7");
    step(10);

    // 3-cycle glitch on bit 0 must be ignored
    bus.SWITCH_I = 16'h0F01;
    for (int i = 1; i <= 10; i++) push_exp(i, 16'h0F00, 4'b0100, 3'd0, "glitch_ignored");
    step(3);
    bus.SWITCH_I = 16'h0F00;
    step(10);

    // Mode walk over the six functions
    bus.SWITCH_I = 16'h0F31;
    push_exp(8, 16'h0F31, gtab[0], 3'd0, "and_0f31");
    step(10);
    m = 0;
    for (int k = 0; k < 6; k++) begin
      bus.PUSH_BUTTON_N_I = 1'b0;
      push_exp(6, 16'h0F31, gtab[m],           3'(m),           "press_not_yet");
      push_exp(7, 16'h0F31, gtab[m],           3'((m + 1) % 6), "mode_step");
      push_exp(8, 16'h0F31, gtab[(m + 1) % 6], 3'((m + 1) % 6), "green_step");
      step(10);
      bus.PUSH_BUTTON_N_I = 1'b1;
      step(12);
      m = (m + 1) % 6;
    end

    // Long hold advances exactly once
    bus.PUSH_BUTTON_N_I = 1'b0;
    push_exp(7,  16'h0F31, gtab[0], 3'd1, "hold_adv");
    push_exp(50, 16'h0F31, gtab[1], 3'd1, "hold_mid");
    push_exp(99, 16'h0F31, gtab[1], 3'd1, "hold_end");
    step(100);
    bus.PUSH_BUTTON_N_I = 1'b1;
    push_exp(20, 16'h0F31, gtab[1], 3'd1, "after_release");
    step(25);

    // One-cycle reset in the middle of a switch debounce
    bus.SWITCH_I = 16'h8F31;
    step(3);
    rst_n = 1'b0;
    push_exp(1, 16'h0, 4'hF, 3'd0, "reset_mid");
    step(1);
    rst_n = 1'b1;
    push_exp(1, 16'h0000, 4'h0,    3'd0, "rst_green_and0");
    push_exp(5, 16'h0000, 4'h0,    3'd0, "redebounce_wait");
    push_exp(6, 16'h8F31, 4'h0,    3'd0, "redebounce_red");
    push_exp(7, 16'h8F31, 4'b0100, 3'd0, "redebounce_green");
    step(10);

`ifdef SWITCH_EVAL_TOGGLE_CNT_EN
    rst_n = 1'b0;
    push_expt(1, 16'h0, 4'hF, 3'd0, 0, "tcnt_reset");
    step(1);
    rst_n = 1'b1;
    step(10);
    for (int k = 0; k < 300; k++) begin
      bus.SWITCH_I = (k % 2 == 0) ? 16'hFF31 : 16'h0F31;
      step(10);
    end
    push_expt(1, 16'h0F31, 4'b0100, 3'd0, 255, "tcnt_saturate");
    step(2);
    rst_n = 1'b0;
    push_expt(1, 16'h0, 4'hF, 3'd0, 0, "tcnt_reset_again");
    step(1);
    rst_n = 1'b1;
`endif

    step(5);
    for (int i = 0; i < 100 && sbq.size() > 0; i++) step(1);
    while (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never compared, due cyc=%0d, now cyc=%0d", sbq[0].name, sbq[0].cyc, cyc);
      void'(sbq.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/switch_logic_eval.md
Name: switch_logic_eval

Overview:
Parametrised successor of the DE2 switch/LED boolean-function block. Switches are split into NUM_GROUPS groups of GROUP_W bits. Every switch and the push button are synchronised and debounced. One selectable reduction function is evaluated per group and shown on a green LED. A debounced push-button press steps through six function modes. The block sits directly behind the board switch, button and LED pins.

Parameters:
NUM_GROUPS, 4, number of switch groups and green-LED result bits
GROUP_W, 4, switches per group (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new level (>=1; 1 ms at 50 MHz)

Ports:
CLOCK_50_I  in  1  system clock, all logic on rising edge
RESETN_I  in  1  reset, synchronous, active-low
SWITCH_I  in  NUM_GROUPS*GROUP_W  raw toggle switches; group g = bits [g*GROUP_W +: GROUP_W]
PUSH_BUTTON_N_I  in  1  raw push button, active-low (0 = pressed)
LED_RED_O  out  NUM_GROUPS*GROUP_W  debounced switch levels
LED_GREEN_O  out  NUM_GROUPS  per-group function result, bit g = group g
MODE_O  out  3  current function mode

Behaviour:
- Reset: applied when RESETN_I=0 at a clock edge.
  - Synchroniser flops for switches reset to 0; button synchroniser flops reset to 1.
  - Debounce counters reset to 0; stable switch levels reset to 0; stable button level resets to 1.
  - MODE_O=0 (AND); LED_RED_O=0.
  - LED_GREEN_O resets to all 1s (AND reduction of all-zero inputs would give 0, but the reset value is fixed at all 1s). The first post-reset cycle then registers AND(0)=0.
  - Reset mid-debounce discards all partial counts.
- Synchroniser: two flops per input bit; synchronised value lags the pin by 2 cycles.
- Debounce, independent per bit (each switch and the button):
  - Synchronised value equals stable value: counter cleared.
  - Values differ: counter increments.
  - Values differ and counter == DEBOUNCE_CYCLES-1: stable value takes the synchronised value and counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable value.
  - DEBOUNCE_CYCLES=1: stable value follows the synchroniser with 1 cycle of delay.
- Latency:
  - Pin edge to LED_RED_O: 2 + DEBOUNCE_CYCLES cycles.
  - Pin edge to LED_GREEN_O: 3 + DEBOUNCE_CYCLES cycles.
- LED_RED_O equals the stable switch register.
- Mode FSM states: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - A press is a stable-button 1->0 transition and advances the mode by 1.
  - From 5 the mode wraps to 0.
  - Release does nothing. A held button advances the mode exactly once.
  - Codes 6 and 7 are unreachable. If entered, the FSM goes to 0 on the next cycle.
- LED_GREEN_O is registered, 1 cycle after the stable switches or mode change.
  - Each bit is the selected reduction over its group.
  - A mode change and a switch change in the same cycle both take effect in the same following cycle.

Optional Feature:
Macro: SWITCH_EVAL_TOGGLE_CNT_EN.
- Defined:
  - Adds output TOGGLE_COUNT_O, 8 bits.
  - Counts clock edges on which the registered LED_GREEN_O changes value, counting at most +1 per edge even when several bits change.
  - Saturates at 255. Reset value 0.
  - The count also increments on a change caused only by a mode change.
- Not defined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
1. Bench uses DEBOUNCE_CYCLES=4, NUM_GROUPS=4, GROUP_W=4.
   - Reset with SWITCH_I=16'h0000 -> LED_RED_O=0, MODE_O=0; LED_GREEN_O=4'hF during reset, then 4'h0 one cycle after reset release.
2. Set SWITCH_I=16'h0F00 and hold -> LED_RED_O=16'h0F00 exactly 6 cycles after the edge; LED_GREEN_O=4'b0100 at 7 cycles.
3. With SWITCH_I=16'h0F00 stable, pulse SWITCH_I[0] high for 3 cycles -> LED_RED_O and LED_GREEN_O unchanged throughout.
4. Step through the six modes with 6 clean presses (each held 10 cycles) using stable input SWITCH_I=16'h0F31:
   - MODE_O sequence 1,2,3,4,5,0.
   - LED_GREEN_O at each step:
     - OR = 4'b0111
     - XOR = 4'b0001 (group 0 = 4'h1 → odd parity 1; group 1 = 4'h3 → even parity 0)
     - NAND = 4'b1011
     - NOR = 4'b1000
     - XNOR = 4'b1110
     - AND = 4'b0100
5. Hold the button pressed for 100 cycles -> MODE_O advances exactly once. Assert RESETN_I=0 for 1 cycle mid-debounce of a switch edge -> all outputs at reset values, and the edge is re-debounced from count 0.
6. With SWITCH_EVAL_TOGGLE_CNT_EN defined:
   - Toggle SWITCH_I[15:12] between 4'hF and 4'h0 300 times (each level held 10 cycles, at mode AND) -> TOGGLE_COUNT_O saturates at 255.
   - Reset -> TOGGLE_COUNT_O=0.
